ysyx_ifu_align: RTL and testbench
=================================

# ysyx_ifu_align

Fetch-realignment queue between the IFU fetch port and the IDU. It buffers 32-bit fetch words and splits them into RVC (16-bit) and 32-bit instructions, including 32-bit instructions that straddle two fetch words. Each instruction is presented to the IDU with pc, sequential pnpc, and any fetch trap. The block drops all buffered state on a pipeline flush.

## Interface
- XLEN, default `YSYX_XLEN`: address and cause width.
- DEPTH, default 4: number of fetch-word queue entries; must be a power of 2, minimum 2.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-low.
- flush  in  1  cmu_bcast.flush_pipe.
- in_valid  in  1  fetch word offered.
- in_ready  out  1  fetch word accepted when in_valid && in_ready.
- in_pc  in  XLEN  fetch address; bit1 is significant only for the first word after reset or flush.
- in_data  in  32  fetch word, little-endian halfwords.
- in_trap  in  1  fetch fault on this word.
- in_cause  in  XLEN  fault cause.
- out_valid  out  1  instruction offered to the IDU.
- out_ready  in  1  IDU ready.
- out_inst  out  32  instruction; RVC is zero-extended to {16'h0, half}.
- out_pc  out  XLEN  instruction address.
- out_pnpc  out  XLEN  out_pc + 2 for RVC, out_pc + 4 otherwise.
- out_trap  out  1  fetch fault attributed to this instruction.
- out_cause  out  XLEN  fault cause.

## Operation
- Queue entries: {pc[XLEN-1:2], data, trap, cause}.
- Pointers: head and tail, log2(DEPTH) bits wide, wrapping. Count is log2(DEPTH)+1 bits wide.
- hoff: 1-bit halfword offset into the head entry. out_pc = {head.pc, hoff, 1'b0}.
- Push into an empty queue (after reset or flush) sets hoff <= in_pc[1]. Later pushes must be word-sequential; the block does not check this.
- Let half = hoff ? head.data[31:16] : head.data[15:0]. The instruction is RVC when half[1:0] != 2'b11.
- On a fire (out_valid && out_ready):
  - hoff=0, RVC: emit half; hoff <= 1; no pop.
  - hoff=0, 32-bit: emit head.data; pop; hoff stays 0.
  - hoff=1, RVC: emit half; pop; hoff <= 0.
  - hoff=1, 32-bit (straddle): emit {next.data[15:0], half}; pop head; hoff stays 1.
- out_valid requires count >= 1 and state RUN. A straddle additionally requires count >= 2, unless head.trap is set.
- Trap rules:
  - If head.trap is set, emit out_trap=1, out_cause=head.cause, out_inst=0.
  - If a straddle's second entry has trap set, emit the trap at the straddle pc with next.cause.
  - After a trap fires, go to HOLD.
- State machine:
  - RUN -> HOLD on trap fire.
  - HOLD -> RUN on flush only.
  - out_valid=0 in HOLD.
- Flush has highest priority:
  - Count, pointers, and hoff go to 0; state goes to RUN.
  - A push or fire in the same cycle is discarded and changes no state.
  - out_valid is not masked during the flush cycle; the consumer ignores it.
- Reset values:
  - state RUN; count, pointers, and hoff 0; all entries 0.
  - Hence out_valid=0, in_ready=1, and out_inst/out_pc/out_pnpc/out_trap/out_cause all 0.

## Timing
- in_ready = (count != DEPTH). It is a registered-state function with no pop bypass. A full queue accepts nothing, even if a pop happens in the same cycle.
- A word pushed at cycle N is visible on out_* at N+1. Outputs are combinational from the head entry, the next entry, and hoff.
- A push and a pop in the same cycle leave count unchanged. Wrap-around at DEPTH-1 -> 0 is transparent.
- While out_valid && !out_ready, all out_* are stable.
- If a straddle is waiting on its second word, that word arrives at N, and out_valid rises at N+1.
- Throughput: up to one instruction per cycle. An RVC pair from one word takes 2 cycles.
- Reset deasserting mid-stream needs no special handling: all state is already cleared.

## Structure
- Shared package (ysyx.svh): entry struct, align state enum {RUN, HOLD}, RVC-detect macro.
- Top-level port mapping: out_* connect to ifu_idu_if fields inst, pc, pnpc, trap, cause, valid, ready.
- Natural sub-module: ysyx_ifu_align_fifo. It holds the DEPTH-entry storage, pointers, and count, and exposes head/next read ports plus push/pop/flush.

## Test plan
- Single 32-bit word: push pc 0x80000000, data 0x00000513 -> next cycle out_inst 0x00000513, pc 0x80000000, pnpc 0x80000004; queue empties.
- RVC pair: push data 0x45814501 -> 0x00004501 at pc ..00 / pnpc ..02, then 0x00004581 at pc ..02 / pnpc ..04; exactly one pop.
- Straddle: push 0x05134501, then 0x45810000 -> 0x4501 at pc 0; 0x00000513 at pc 2 / pnpc 6; 0x4581 at pc 6. Delaying the second word 5 cycles keeps out_valid=0 until one cycle after its push.
- Backpressure, DEPTH=4: hold out_ready=0 and offer 5 words -> in_ready=0 after the 4th push; out_* stable; the 5th word is accepted the cycle after the first pop.
- Trap then flush: push a word with trap=1, cause 1 -> out_trap=1, cause 1, inst 0; then out_valid=0 despite queued words. Flush with a simultaneous push -> push discarded. Next push at pc 0x80000102, data 0x4501xxxx -> 0x4501 at pc 0x80000102.
- Async reset asserted mid-straddle -> out_valid=0 and in_ready=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ysyx_ifu_align_pkg.sv
// Shared types and helpers for the IFU fetch-realignment queue.
package ysyx_ifu_align_pkg;

  localparam int YSYX_XLEN = 32;

  typedef enum logic {
    ALIGN_RUN  = 1'b0,
    ALIGN_HOLD = 1'b1
  } align_state_e;

  // Any halfword whose low two bits are not 2'b11 opens a compressed instruction.
  function automatic logic is_rvc(input logic [15:0] half);
    return half[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/ysyx_ifu_align_fifo.sv
// Fetch-word storage with head/next read ports; writes land in the cycle after push.
// Zero-latency reads; the caller must not push when full or pop when empty.
module ysyx_ifu_align_fifo #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            push,
  input  logic [XLEN-3:0] push_pc,
  input  logic [31:0]     push_data,
  input  logic            push_trap,
  input  logic [XLEN-1:0] push_cause,
  input  logic            pop,
  output logic            full,
  output logic [AW:0]     count,
  output logic [XLEN-3:0] head_pc,
  output logic [31:0]     head_data,
  output logic            head_trap,
  output logic [XLEN-1:0] head_cause,
  output logic [31:0]     next_data,
  output logic            next_trap,
  output logic [XLEN-1:0] next_cause
);

  typedef struct packed {
    logic [XLEN-3:0] pc;
    logic [31:0]     data;
    logic            trap;
    logic [XLEN-1:0] cause;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW-1:0] head_nx;

  assign head_nx    = head + 1'b1;
  assign full       = count == (AW+1)'(DEPTH);
  assign head_pc    = mem[head].pc;
  assign head_data  = mem[head].data;
  assign head_trap  = mem[head].trap;
  assign head_cause = mem[head].cause;
  assign next_data  = mem[head_nx].data;
  assign next_trap  = mem[head_nx].trap;
  assign next_cause = mem[head_nx].cause;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[tail] <= '{pc: push_pc, data: push_data, trap: push_trap, cause: push_cause};
        tail      <= tail + 1'b1;
      end
      if (pop) head <= head_nx;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ysyx_ifu_align.sv
// Splits queued 32-bit fetch words into RVC/32-bit instructions for the IDU; a pushed word is visible next cycle.
// in_ready is simply "not full" (no pop bypass); out_* hold steady while out_ready is low.
module ysyx_ifu_align
  import ysyx_ifu_align_pkg::*;
#(
  parameter int XLEN  = YSYX_XLEN,
  parameter int DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_data,
  input  logic            in_trap,
  input  logic [XLEN-1:0] in_cause,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pnpc,
  output logic            out_trap,
  output logic [XLEN-1:0] out_cause
);

  localparam int AW = $clog2(DEPTH);

  align_state_e    state, state_nx;
  logic            hoff, hoff_nx;
  logic            full, push, pop, fire;
  logic [AW:0]     count;
  logic [XLEN-3:0] head_pc;
  logic [31:0]     head_data, next_data;
  logic            head_trap, next_trap;
  logic [XLEN-1:0] head_cause, next_cause;
  logic [15:0]     half;
  logic            nonempty, has_two, rvc, straddle, next_fault, trap_hit;
  logic [XLEN-1:0] pc_raw;
  logic            unused_pc0;

  assign unused_pc0 = in_pc[0];

  ysyx_ifu_align_fifo #(.XLEN(XLEN), .DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .flush      (flush),
    .push       (push),
    .push_pc    (in_pc[XLEN-1:2]),
    .push_data  (in_data),
    .push_trap  (in_trap),
    .push_cause (in_cause),
    .pop        (pop),
    .full       (full),
    .count      (count),
    .head_pc    (head_pc),
    .head_data  (head_data),
    .head_trap  (head_trap),
    .head_cause (head_cause),
    .next_data  (next_data),
    .next_trap  (next_trap),
    .next_cause (next_cause)
  );

  assign nonempty   = count != '0;
  assign has_two    = count[AW:1] != '0;
  assign half       = hoff ? head_data[31:16] : head_data[15:0];
  assign rvc        = is_rvc(half);
  assign straddle   = hoff && !rvc;
  // A faulting second word is only trusted once it is actually in the queue.
  assign next_fault = straddle && has_two && next_trap;
  assign trap_hit   = head_trap || next_fault;
  assign pc_raw     = {head_pc, hoff, 1'b0};

  assign in_ready  = !full;
  assign out_valid = (state == ALIGN_RUN) && nonempty && (!straddle || has_two || head_trap);

  always_comb begin
    out_inst  = '0;
    out_pc    = '0;
    out_pnpc  = '0;
    out_trap  = 1'b0;
    out_cause = '0;
    if (nonempty) begin
      out_pc   = pc_raw;
      out_pnpc = pc_raw + (rvc ? XLEN'(2) : XLEN'(4));
      out_trap = trap_hit;
      if (head_trap)       out_cause = head_cause;
      else if (next_fault) out_cause = next_cause;
      if (!trap_hit) begin
        if (rvc)       out_inst = {16'h0, half};
        else if (hoff) out_inst = {next_data[15:0], half};
        else           out_inst = head_data;
      end
    end
  end

  assign fire = out_valid && out_ready && !flush;
  assign push = in_valid && in_ready && !flush;
  assign pop  = fire && !trap_hit && (hoff || !rvc);

  always_comb begin
    state_nx = state;
    hoff_nx  = hoff;
    if (flush) begin
      state_nx = ALIGN_RUN;
      hoff_nx  = 1'b0;
    end else begin
      if (push && !nonempty) hoff_nx = in_pc[1];
      if (fire) begin
        if (trap_hit)  state_nx = ALIGN_HOLD;
        else if (rvc)  hoff_nx  = !hoff;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ALIGN_RUN;
      hoff  <= 1'b0;
    end else begin
      state <= state_nx;
      hoff  <= hoff_nx;
    end
  end

endmodule

// File: tb/tb_ysyx_ifu_align.sv
// Directed bench for ysyx_ifu_align: expected instructions are queued at issue time and
// checked by an independent monitor whenever the IDU side fires.
module tb_ysyx_ifu_align;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_pc = '0;
  logic [31:0] in_data = '0;
  logic        in_trap = 1'b0;
  logic [31:0] in_cause = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_inst, out_pc, out_pnpc, out_cause;
  logic        out_trap;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] pnpc;
    logic        trap;
    logic [31:0] cause;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   passed = 0;

  ysyx_ifu_align #(.XLEN(32), .DEPTH(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_data   (in_data),
    .in_trap   (in_trap),
    .in_cause  (in_cause),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .out_pnpc  (out_pnpc),
    .out_trap  (out_trap),
    .out_cause (out_cause)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic expect_inst(input logic [31:0] inst, input logic [31:0] pc,
                             input logic [31:0] pnpc, input logic trap, input logic [31:0] cause);
    exp_q.push_back('{inst: inst, pc: pc, pnpc: pnpc, trap: trap, cause: cause});
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepted the word.
  task automatic push(input logic [31:0] pc, input logic [31:0] data,
                      input logic trap, input logic [31:0] cause);
    bit ok = 1'b0;
    in_valid = 1'b1; in_pc = pc; in_data = data; in_trap = trap; in_cause = cause;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) chk("push_timeout", 64'd0, 64'd1);
    @(posedge clock);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0) begin ok = 1'b1; break; end
      @(posedge clock);
      #1;
    end
    if (!ok) chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: every IDU-side handshake must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clock);
      if (reset && !flush && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_fire_pc", 64'(out_pc), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("mon_inst",  64'(out_inst),  64'(e.inst));
          chk("mon_pc",    64'(out_pc),    64'(e.pc));
          chk("mon_pnpc",  64'(out_pnpc),  64'(e.pnpc));
          chk("mon_trap",  64'(out_trap),  64'(e.trap));
          chk("mon_cause", 64'(out_cause), 64'(e.cause));
        end
      end
    end
  end

  initial begin
    logic [31:0] bp_data [5];
    bp_data[0] = 32'h00100093; bp_data[1] = 32'h00200113; bp_data[2] = 32'h00300193;
    bp_data[3] = 32'h00400213; bp_data[4] = 32'h00500293;

    // Reset state
    #3;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_inst",  64'(out_inst),  64'd0);
    chk("rst_out_pc",    64'(out_pc),    64'd0);
    chk("rst_out_pnpc",  64'(out_pnpc),  64'd0);
    chk("rst_out_trap",  64'(out_trap),  64'd0);
    chk("rst_out_cause", 64'(out_cause), 64'd0);
    #9 reset = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b1;

    // Single 32-bit word
    expect_inst(32'h00000513, 32'h80000000, 32'h80000004, 1'b0, 32'h0);
    push(32'h80000000, 32'h00000513, 1'b0, 32'h0);
    chk("single_latency_valid", 64'(out_valid), 64'd1);
    drain();
    chk("single_empty_valid", 64'(out_valid), 64'd0);

    // RVC pair from one word
    expect_inst(32'h00004501, 32'h80000000, 32'h80000002, 1'b0, 32'h0);
    expect_inst(32'h00004581, 32'h80000002, 32'h80000004, 1'b0, 32'h0);
    push(32'h80000000, 32'h45814501, 1'b0, 32'h0);
    drain();
    @(posedge clock); #1;
    chk("rvc_pair_empty_valid", 64'(out_valid), 64'd0);

    // Straddle with the second word delayed
    expect_inst(32'h00004501, 32'h80000000, 32'h80000002, 1'b0, 32'h0);
    expect_inst(32'h00000513, 32'h80000002, 32'h80000006, 1'b0, 32'h0);
    expect_inst(32'h00004581, 32'h80000006, 32'h80000008, 1'b0, 32'h0);
    push(32'h80000000, 32'h05134501, 1'b0, 32'h0);
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) begin
      chk("straddle_wait_valid", 64'(out_valid), 64'd0);
      @(posedge clock); #1;
    end
    push(32'h80000004, 32'h45810000, 1'b0, 32'h0);
    chk("straddle_rise_valid", 64'(out_valid), 64'd1);
    drain();

    // Backpressure with a full queue
    @(posedge clock); #1;
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++)
      expect_inst(bp_data[k], 32'h80001000 + 32'(4 * k), 32'h80001004 + 32'(4 * k), 1'b0, 32'h0);
    for (int k = 0; k < 4; k++)
      push(32'h80001000 + 32'(4 * k), bp_data[k], 1'b0, 32'h0);
    chk("bp_full_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_pc = 32'h80001010; in_data = bp_data[4]; in_trap = 1'b0; in_cause = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("bp_stall_in_ready", 64'(in_ready),  64'd0);
      chk("bp_stable_inst",    64'(out_inst),  64'(bp_data[0]));
      chk("bp_stable_pc",      64'(out_pc),    64'h80001000);
      chk("bp_stable_valid",   64'(out_valid), 64'd1);
    end
    @(posedge clock); #1;
    out_ready = 1'b1;
    @(negedge clock);
    chk("bp_no_bypass_in_ready", 64'(in_ready), 64'd0);
    @(negedge clock);
    chk("bp_after_pop_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    drain();

    // Trap, HOLD, then flush with a simultaneous push
    @(posedge clock); #1;
    expect_inst(32'h0, 32'h80000100, 32'h80000104, 1'b1, 32'h1);
    push(32'h80000100, 32'h00000013, 1'b1, 32'h1);
    push(32'h80000104, 32'h00000513, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      chk("hold_valid", 64'(out_valid), 64'd0);
      @(posedge clock); #1;
    end
    flush = 1'b1;
    in_valid = 1'b1; in_pc = 32'h80000200; in_data = 32'h00000013; in_trap = 1'b0; in_cause = '0;
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock); #1;
    chk("flush_push_dropped_valid", 64'(out_valid), 64'd0);
    expect_inst(32'h00004501, 32'h80000102, 32'h80000104, 1'b0, 32'h0);
    push(32'h80000102, 32'h45010001, 1'b0, 32'h0);
    chk("post_flush_valid", 64'(out_valid), 64'd1);
    drain();

    // Asynchronous reset while a straddle is being offered
    @(posedge clock); #1;
    expect_inst(32'h00004501, 32'h80000000, 32'h80000002, 1'b0, 32'h0);
    push(32'h80000000, 32'h05134501, 1'b0, 32'h0);
    @(posedge clock); #1;
    out_ready = 1'b0;
    push(32'h80000004, 32'h45810000, 1'b0, 32'h0);
    chk("areset_pre_valid", 64'(out_valid), 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("areset_out_valid", 64'(out_valid), 64'd0);
    chk("areset_in_ready",  64'(in_ready),  64'd1);
    chk("areset_out_pc",    64'(out_pc),    64'd0);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
